// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised single-accumulator CPU (HLT/SKZ/ADD/AND/XOR/LDA/STO/JMP) on a req/ready memory bus.
// Optional bus watchdog enabled by defining CPU_WDOG_EN (times out after TIMEOUT wait cycles).
`timescale 1ns/1ps
module cpu_core_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halt,
  output logic              bus_err,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEMRD  = 3'd3,
    S_MEMWR  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] ir_q;

  logic [2:0]        opcode_s;
  logic [ADDR_W-1:0] addr_s;
  logic              zero_s;
  logic              xfer_done_s;
  logic              wdog_trip_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic [DATA_W-1:0] alu_s;
  logic              ir_unused_s;

  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_LDA:  r = b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Bits between the opcode and the address field carry no meaning.
  assign opcode_s    = ir_q[DATA_W-1 -: 3];
  assign addr_s      = ir_q[ADDR_W-1:0];
  assign ir_unused_s = ^ir_q;
  assign zero_s      = (acc_q == '0);
  assign alu_s       = alu_f(opcode_s, acc_q, mem_rdata);
  assign xfer_done_s = mem_req & mem_ready;

  // Next PC chosen in DECODE: jump target, skip-by-two on zero, otherwise increment.
  always_comb begin
    pc_next_s = pc_q + ADDR_W'(1);
    if (opcode_s == OP_JMP) begin
      pc_next_s = addr_s;
    end else if ((opcode_s == OP_SKZ) && zero_s) begin
      pc_next_s = pc_q + ADDR_W'(2);
    end else begin
      pc_next_s = pc_q + ADDR_W'(1);
    end
  end

  // Bus signals decode straight from the state register so they hold steady across wait states.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = addr_s;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_s;
      end
      default: begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
      end
    endcase
  end

`ifdef CPU_WDOG_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wcnt_q;
  logic             bus_err_q;
  logic             stall_s;

  assign stall_s     = mem_req & ~mem_ready;
  assign wdog_trip_s = stall_s & (wcnt_q == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter; any completed or idle cycle restarts it for the next transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (stall_s) begin
        wcnt_q <= wcnt_q + CNT_W'(1);
      end else begin
        wcnt_q <= '0;
      end
      if (wdog_trip_s) begin
        bus_err_q <= 1'b1;
      end else begin
        bus_err_q <= bus_err_q;
      end
    end
  end

  assign bus_err = bus_err_q;
`else
  assign wdog_trip_s = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // Main sequencer: fetch, decode, optional operand transfer, halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (wdog_trip_s) begin
            state_q <= S_HALTED;
          end else if (xfer_done_s) begin
            ir_q    <= mem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          pc_q <= pc_next_s;
          case (opcode_s)
            OP_HLT:         state_q <= S_HALTED;
            OP_SKZ, OP_JMP: state_q <= S_FETCH;
            OP_STO:         state_q <= S_MEMWR;
            default:        state_q <= S_MEMRD;
          endcase
        end
        S_MEMRD: begin
          if (wdog_trip_s) begin
            state_q <= S_HALTED;
          end else if (xfer_done_s) begin
            acc_q   <= alu_s;
            state_q <= S_FETCH;
          end
        end
        S_MEMWR: begin
          if (wdog_trip_s) begin
            state_q <= S_HALTED;
          end else if (xfer_done_s) begin
            state_q <= S_FETCH;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_wdata = acc_q;
  assign halt      = (state_q == S_HALTED);
  assign pc_dbg    = pc_q;
  assign acc_dbg   = acc_q;
  assign state_dbg = state_q;

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised successor to the 8-opcode accumulator CPU.
- Same ISA (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) and single accumulator.
- Generalised data and address widths; replaces the fixed-timing internal memory with an external req/ready memory bus that tolerates wait states.
- Sits between the system bus and the instruction/data memory; exposes PC, ACC and state for debug.

Parameters:
- DATA_W, 8, data, accumulator and instruction word width; must be ≥ ADDR_W+3.
- ADDR_W, 5, address width; PC and operand address wrap mod 2^ADDR_W.
- TIMEOUT, 15, wait-state limit in cycles; used only with CPU_WDOG_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  bus transfer request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  transfer address.
- mem_wdata  out  DATA_W  write data; equals ACC.
- mem_rdata  in  DATA_W  read data; sampled on the completing edge.
- mem_ready  in  1  transfer completes on an edge where mem_req & mem_ready.
- halt  out  1  sticky; core stopped.
- bus_err  out  1  watchdog timeout flag (see Optional Feature).
- pc_dbg  out  ADDR_W  current PC.
- acc_dbg  out  DATA_W  current ACC.
- state_dbg  out  3  state encoding.

Behaviour:
- Reset (rst=0, asynchronous, any cycle, including mid-transfer):
  - State = IDLE; PC, ACC, IR = 0; halt, bus_err = 0.
  - mem_req, mem_we = 0 immediately; an in-flight transfer is abandoned.
- Instruction word:
  - opcode = IR[DATA_W-1 -: 3]; operand address = IR[ADDR_W-1:0].
  - Bits between the opcode and the address field are ignored.
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- zero = (ACC == 0), combinational from ACC.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMRD=3, MEMWR=4, HALTED=5.
- IDLE: mem_req=0 → FETCH on the next edge. The first request appears 1 cycle after rst rises.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PC.
  - Stays while mem_ready=0; address is held stable.
  - On the completing edge: IR ← mem_rdata → DECODE.
- DECODE: mem_req=0; PC ← PC+1 (wraps), except where noted.
  - HLT → HALTED; PC still increments.
  - SKZ: PC ← PC+2 if zero, else PC+1 → FETCH.
  - JMP: PC ← addr (no increment) → FETCH.
  - ADD/AND/XOR/LDA → MEMRD.
  - STO → MEMWR.
- MEMRD:
  - Drives mem_req=1, mem_we=0, mem_addr=addr.
  - On completion, ACC ← result → FETCH:
    - ADD: (ACC+rdata) mod 2^DATA_W; carry discarded.
    - AND: ACC & rdata.
    - XOR: ACC ^ rdata.
    - LDA: rdata.
- MEMWR:
  - Drives mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=ACC.
  - On completion → FETCH. ACC is unchanged.
- HALTED: mem_req=0; halt=1; state held until reset.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are decoded from registered state and stay stable until completion.
  - mem_req deasserts for at least one cycle (DECODE) between fetch and operand transfer.
  - mem_ready while mem_req=0 is ignored.
- Latency with mem_ready tied 1:
  - ADD/AND/XOR/LDA/STO: 3 cycles.
  - SKZ/JMP/HLT: 2 cycles.
  - Each wait cycle adds 1.
- Wrap: PC=2^ADDR_W−1 followed by a non-jump instruction gives PC=0. SKZ taken at PC=2^ADDR_W−2 gives PC=0.

Optional Feature:
- Macro: CPU_WDOG_EN.
- Defined:
  - A counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle with mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT: bus_err ← 1 (sticky), mem_req drops, state → HALTED, halt=1.
- Undefined: no counter; bus_err tied 0; waits are unbounded.

Test Plan:
- LDA / ADD / STO program, zero-wait memory:
  - Program: mem[0]=LDA 20, mem[1]=ADD 21, mem[2]=STO 22, mem[3]=HLT; mem[20]=8'h0F, mem[21]=8'h01.
  - Required: mem[22]=8'h10; halt=1 at cycle 12 after rst release; pc_dbg=4.
- SKZ taken and not taken:
  - ACC=0: SKZ at PC=5 gives PC=7.
  - ACC=8'h01: SKZ at PC=5 gives PC=6.
  - Each takes 2 cycles.
- Wait states:
  - mem_ready low for 3 cycles on every transfer during ADD.
  - Required: mem_addr and mem_we stable throughout; ADD completes in 9 cycles; ACC result correct.
- Overflow and wrap:
  - ADD with ACC=8'hFF, data 8'h02 gives ACC=8'h01.
  - JMP 31, then a non-jump instruction at address 31, gives PC=0.
- Mid-transfer reset:
  - Drop rst during MEMWR with mem_ready=0.
  - Required: mem_req=0 immediately; pc_dbg, acc_dbg, state_dbg all 0; FETCH of address 0 starts 1 cycle after release.
- CPU_WDOG_EN, TIMEOUT=15:
  - Hold mem_ready=0 in FETCH.
  - Required: bus_err=1 and halt=1 after 15 wait cycles; mem_req=0; state_dbg=5.
